// File: rtl/bc_display_scan.sv
// bc_display_scan: time-multiplexed driver for eight seven-segment displays.
// Latches a 32-bit glyph word plus per-digit blank/blink masks and scans them
// out one digit per slot, with a leading all-off guard interval per slot.
// Optional feature macro: BC_DISP_BLINK_EN (per-digit blinking).
module bc_display_scan #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned GUARD     = 4,
    parameter int unsigned BLINK_DIV = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] data,
    input  logic [7:0]  blank,
    input  logic [7:0]  blink,
    output logic [7:0]  an,
    output logic [6:0]  digit
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   sh_data;
    logic [7:0]    sh_blank;
    logic          cnt_last;
    logic          in_guard;
    logic          blink_dark;
    logic          dark;
    logic [4:0]    nib_base;
    logic [3:0]    nibble;

    // Active-low {g..a} pattern per glyph code; code F is the NULL marker.
    function automatic logic [6:0] seg(input logic [3:0] code);
        case (code)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h7F;
        endcase
    endfunction

    assign cnt_last = (cnt == CW'(SCAN_DIV - 1));

    // Guard interval only exists when GUARD is non-zero.
    if (GUARD > 0) begin : g_guard
        assign in_guard = (cnt < CW'(GUARD));
    end else begin : g_no_guard
        assign in_guard = 1'b0;
    end

`ifdef BC_DISP_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [7:0]    sh_blink;
    logic [BW-1:0] scan_cnt;
    logic          phase;

    // Blink mask shadow, scan counter and blink phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            sh_blink <= 8'h00;
            scan_cnt <= '0;
            phase    <= 1'b0;
        end else begin
            if (load) begin
                sh_blink <= blink;
            end
            if (cnt_last && (idx == 3'd7)) begin
                if (scan_cnt == BW'(BLINK_DIV - 1)) begin
                    scan_cnt <= '0;
                    phase    <= ~phase;
                end else begin
                    scan_cnt <= scan_cnt + BW'(1);
                end
            end
        end
    end

    assign blink_dark = phase & sh_blink[idx];
`else
    localparam int unsigned unused_blink_div = BLINK_DIV;
    logic unused_blink;

    assign unused_blink = ^blink;
    assign blink_dark   = 1'b0;
`endif

    // Darkness decision and glyph selection from current state.
    always_comb begin
        nib_base = {idx, 2'b00};
        nibble   = sh_data[nib_base +: 4];
        dark     = in_guard | sh_blank[idx] | blink_dark;
    end

    // Shadows, scan counters and registered pin outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            sh_data  <= 32'h0;
            sh_blank <= 8'hFF;
            cnt      <= '0;
            idx      <= 3'd0;
            an       <= 8'hFF;
            digit    <= 7'h7F;
        end else begin
            if (load) begin
                sh_data  <= data;
                sh_blank <= blank;
            end
            if (cnt_last) begin
                cnt <= '0;
                idx <= idx + 3'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (dark) begin
                an    <= 8'hFF;
                digit <= 7'h7F;
            end else begin
                an    <= ~(8'b1 << idx);
                digit <= seg(nibble);
            end
        end
    end

endmodule

// File: tb/tb_bc_display_scan.sv
// Directed bench for bc_display_scan with SCAN_DIV=8, GUARD=2, BLINK_DIV=1.
module tb_bc_display_scan;

    localparam int unsigned SD = 8;
    localparam int unsigned GD = 2;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F
    };
    localparam logic [7:0] AN_TAB [8] = '{
        8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F
    };

    logic        clock = 1'b0;
    logic        reset;
    logic        load;
    logic [31:0] data;
    logic [7:0]  blank;
    logic [7:0]  blink;
    logic [7:0]  an;
    logic [6:0]  digit;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    logic [31:0] m_data;
    logic [7:0]  m_blank;
    logic [7:0]  m_blink;

    always #5 clock = ~clock;

    bc_display_scan #(.SCAN_DIV(SD), .GUARD(GD), .BLINK_DIV(1)) dut (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .data  (data),
        .blank (blank),
        .blink (blink),
        .an    (an),
        .digit (digit)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (edge %0d)", tag, got, exp, edges);
        end
    endtask

    // One edge with optional load; expected outputs from the pre-edge shadows.
    task automatic step(input logic ld, input logic [31:0] d, input logic [7:0] bl,
                        input logic [7:0] bk, input string tag);
        int pos, c, s, scan;
        bit dk;
        logic [7:0] e_an;
        logic [6:0] e_dig;
        load  = ld;
        data  = d;
        blank = bl;
        blink = bk;
        @(posedge clock);
        edges++;
        @(negedge clock);
        load = 1'b0;
        pos  = edges - 1;
        c    = pos % SD;
        s    = (pos / SD) % 8;
        scan = pos / (SD * 8);
        dk   = (c < GD) || m_blank[s];
`ifdef BC_DISP_BLINK_EN
        if (m_blink[s] && (scan % 2 == 1)) dk = 1'b1;
`endif
        e_an  = dk ? 8'hFF : AN_TAB[s];
        e_dig = dk ? 7'h7F : GLYPH[m_data[4*s +: 4]];
        check({tag, "_an"}, 32'(an), 32'(e_an));
        check({tag, "_digit"}, 32'(digit), 32'(e_dig));
        if (ld) begin
            m_data  = d;
            m_blank = bl;
            m_blink = bk;
        end
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 8'h0, 8'h0, tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        load  = 1'b0;
        @(posedge clock);
        @(negedge clock);
        edges   = 0;
        m_data  = 32'h0;
        m_blank = 8'hFF;
        m_blink = 8'h00;
        check({tag, "_an"}, 32'(an), 32'h0000_00FF);
        check({tag, "_digit"}, 32'(digit), 32'h0000_007F);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        data  = 32'h0;
        blank = 8'h0;
        blink = 8'h0;
        @(negedge clock);
        do_reset("reset");

        // Plain scan of 0..7, display 0 marked to blink.
        step(1'b1, 32'h7654_3210, 8'h00, 8'h01, "scan0");
        run(63, "scan0");
        run(64, "scan1_blink");

        // Lower four displays blanked.
        step(1'b1, 32'h7654_3210, 8'h0F, 8'h00, "blank");
        run(127, "blank");

        // NULL nibble in slot 2, 'A' in slot 4.
        step(1'b1, 32'hBCDA_EF10, 8'h00, 8'h00, "glyph");
        run(63, "glyph");
        while (edges % 64 != 31) step(1'b0, 32'h0, 8'h0, 8'h0, "glyph");

        // New data lands on the slot 3 -> 4 boundary edge.
        step(1'b1, 32'h0000_0000, 8'h00, 8'h00, "slotchg");
        run(40, "slotchg");

        // Reset in the middle of lit slot 5.
        while (edges % 64 != 44) step(1'b0, 32'h0, 8'h0, 8'h0, "pre_rst");
        check("slot5_lit_an", 32'(an), 32'h0000_00DF);
        do_reset("midreset");
        step(1'b1, 32'h7654_3210, 8'h00, 8'h00, "post_rst");
        step(1'b0, 32'h0, 8'h0, 8'h0, "post_rst");
        step(1'b0, 32'h0, 8'h0, 8'h0, "post_rst");
        check("first_lit_an", 32'(an), 32'h0000_00FE);
        check("first_lit_digit", 32'(digit), 32'h0000_0040);
        run(61, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bc_display_scan.md
# bc_display_scan

Time-multiplexed driver for the eight on-board seven-segment displays of the Bulls & Cows design. Sits directly downstream of the game FSM: it latches the 32-bit display word (eight 4-bit glyph codes) the FSM publishes and scans it onto the `an`/`digit` pins, one digit at a time. It includes per-digit blanking and anti-ghost guard intervals, plus optional per-digit blinking for the win/input prompts.

## Interface
Parameters:
- `SCAN_DIV`, 100000: clock cycles each digit slot is held (100 MHz gives 1 kHz per digit); legal range ≥ 2.
- `GUARD`, 4: leading cycles of each slot during which all anodes are off; legal range 0 ≤ GUARD < SCAN_DIV.
- `BLINK_DIV`, 64: full 8-digit scans per blink half-period; legal range ≥ 1; used only with `BC_DISP_BLINK_EN`.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `load`  in  1  capture strobe for `data`, `blank` and `blink`.
- `data`  in  32  glyph codes; nibble i (`data[4i+3:4i]`) goes to display i; display 0 is rightmost.
- `blank`  in  8  bit i=1: display i dark.
- `blink`  in  8  bit i=1: display i blinks (ignored without `BC_DISP_BLINK_EN`).
- `an`  out  8  anode enables, active-low, one-hot-low or all-high.
- `digit`  out  7  segments {g,f,e,d,c,b,a}, active-low, bit 0 = a.

## Operation
- Shadow registers `sh_data`, `sh_blank` and `sh_blink` are loaded on any edge with `load`=1 and hold otherwise. Reset clears them: data 0, blank 8'hFF, blink 0.
- Counter `cnt` runs 0..SCAN_DIV-1 and wraps to 0. Slot index `idx` (3 bits) increments when `cnt`=SCAN_DIV-1 and wraps 7→0. Reset sets both to 0.
- The display is dark if any of these holds: `cnt` < GUARD; `sh_blank[idx]`; or (blink enabled, `phase`=1 and `sh_blink[idx]`). Dark means `an`=8'hFF and `digit`=7'h7F.
- Otherwise `an` = ~(8'b1 << idx) and `digit` = seg(`sh_data` nibble `idx`).
- Glyph table (active-low {g..a}), in order 0..F: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=7F.
  - Code F is the game's NULL marker and renders blank, so it does not render 'F'.
- No state machine beyond the counters. Scanning never stops while out of reset.

## Timing
- `an` and `digit` are registers updated every edge from the pre-edge values of `cnt`, `idx`, shadows and `phase`, so outputs lag state by 1 cycle.
- Reset values: `an`=8'hFF, `digit`=7'h7F, `cnt`=0, `idx`=0, `phase`=0, plus the shadow values above.
- `load` at edge k affects outputs from edge k+1 onward. If `load` coincides with a slot change, the new slot's first driven value uses the new data.
- Reset asserted mid-slot: the outputs go to reset values on that same edge, and scanning restarts from display 0, `cnt`=0.
- After reset release with GUARD=g, the first non-dark output appears on edge g+1 (counting the first post-reset edge as 1).
- Every slot shows GUARD dark cycles followed by SCAN_DIV-GUARD driven cycles. With GUARD=0, `an` never shows all-high between adjacent lit digits.

## Configuration
- `BC_DISP_BLINK_EN` defined:
  - A 1-bit `phase` register plus a scan counter 0..BLINK_DIV-1 are present; the scan counter advances when `idx` wraps 7→0.
  - `phase` toggles when the scan counter wraps.
  - Displays with `sh_blink` set are dark while `phase`=1.
- Not defined:
  - `phase` is tied to 0, the `blink` port and `sh_blink` are unused, and no blink logic is synthesized.

## Test plan
- SCAN_DIV=8, GUARD=2. Reset, then `load` with `data`=32'h7654_3210 and `blank`=0.
  - Expect: `an` goes through FE,FD,…,7F in order, each held 6 cycles after 2 cycles of FF.
  - Expect: `digit` in slot 0 is 40 and in slot 7 is 78.
- `blank`=8'h0F with `load` → slots 0-3 show `an`=FF and `digit`=7F for the whole slot; slots 4-7 show normally.
- Nibble 4'hF loaded in slot 2 → during slot 2, `an`=FB and `digit`=7F. Nibble 4'hA → `digit`=08.
- Reset pulsed mid-slot 5 → on that edge `an`=FF and `digit`=7F. The next lit slot is display 0, after GUARD dark cycles.
- `load` of new data on the same edge as the slot 3→4 change → slot 4 shows the new nibble from its first driven cycle; slot 3 had shown the old nibble.
- With `BC_DISP_BLINK_EN`, BLINK_DIV=1, `blink`=8'h01: display 0 is lit on even scans and dark on odd scans, while the other displays are unaffected. Without the macro, display 0 is lit on every scan.
